// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared LCD output types, register map and DMG shade colours
package lcd_pkg;

  localparam int LCD_W_DEF = 160;
  localparam int LCD_H_DEF = 144;

  typedef logic [14:0] rgb555_t;

  typedef struct packed {
    logic       is_sprite;
    logic [2:0] pal;
    logic [1:0] idx;
  } mixed_pixel_t;

  typedef enum logic [2:0] {
    REG_BGP  = 3'd0,
    REG_OBP0 = 3'd1,
    REG_OBP1 = 3'd2,
    REG_BCPS = 3'd3,
    REG_BCPD = 3'd4,
    REG_OCPS = 3'd5,
    REG_OCPD = 3'd6,
    REG_NONE = 3'd7
  } reg_sel_e;

  localparam rgb555_t DMG_SHADE_0 = 15'h7FFF;
  localparam rgb555_t DMG_SHADE_1 = 15'h56B5;
  localparam rgb555_t DMG_SHADE_2 = 15'h294A;
  localparam rgb555_t DMG_SHADE_3 = 15'h0000;

  function automatic rgb555_t dmg_colour(input logic [1:0] shade);
    case (shade)
      2'd0:    dmg_colour = DMG_SHADE_0;
      2'd1:    dmg_colour = DMG_SHADE_1;
      2'd2:    dmg_colour = DMG_SHADE_2;
      default: dmg_colour = DMG_SHADE_3;
    endcase
  endfunction

endpackage

// File: rtl/cgb_palette_ram.sv
// rtl/cgb_palette_ram.sv - one 64-byte CGB palette RAM with its index/data register pair
module cgb_palette_ram
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ppu_busy,
  input  logic       spec_wr,
  input  logic       data_wr,
  input  logic [7:0] wdata,
  output logic [7:0] spec_rdata,
  output logic [7:0] data_rdata,
  input  logic [4:0] pix_pair,
  output rgb555_t    pix_rgb
);

  logic [7:0] mem [64];
  logic [5:0] index;
  logic       auto_inc;

  // Auto-increment advances even when the data write itself is blocked by mode 3.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index    <= 6'd0;
      auto_inc <= 1'b0;
    end else if (spec_wr) begin
      index    <= wdata[5:0];
      auto_inc <= wdata[7];
    end else if (data_wr && auto_inc) begin
      index <= index + 6'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'hFF;
    end else if (data_wr && !ppu_busy) begin
      mem[index] <= wdata;
    end
  end

  assign spec_rdata = {auto_inc, 1'b1, index};
  assign data_rdata = ppu_busy ? 8'hFF : mem[index];
  assign pix_rgb    = {mem[{pix_pair, 1'b1}][6:0], mem[{pix_pair, 1'b0}]};

endmodule

// File: rtl/pixel_palette_out.sv
// rtl/pixel_palette_out.sv - resolves mixed PPU pixels to RGB555 and emits an x/y-tagged LCD stream
module pixel_palette_out
  import lcd_pkg::*;
#(
  parameter int LCD_W = LCD_W_DEF,
  parameter int LCD_H = LCD_H_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cgb_mode,
  input  logic        pix_valid,
  input  logic [5:0]  mix_pixel,
  input  logic        frame_start,
  input  logic        ppu_busy,
  input  logic [2:0]  reg_sel,
  input  logic        reg_wr,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  output logic        lcd_valid,
  output logic [7:0]  lcd_x,
  output logic [7:0]  lcd_y,
  output logic [14:0] lcd_rgb
);

  localparam logic [7:0] X_LAST = 8'(LCD_W - 1);
  localparam logic [7:0] Y_LAST = 8'(LCD_H - 1);

  reg_sel_e     sel;
  mixed_pixel_t px;
  assign sel = reg_sel_e'(reg_sel);
  assign px  = mixed_pixel_t'(mix_pixel);

  logic [7:0] bgp, obp0, obp1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bgp  <= 8'h00;
      obp0 <= 8'h00;
      obp1 <= 8'h00;
    end else if (reg_wr) begin
      if (sel == REG_BGP)  bgp  <= reg_wdata;
      if (sel == REG_OBP0) obp0 <= reg_wdata;
      if (sel == REG_OBP1) obp1 <= reg_wdata;
    end
  end

  logic [7:0] bg_spec_rdata, bg_data_rdata, obj_spec_rdata, obj_data_rdata;
  rgb555_t    bg_rgb, obj_rgb;

  cgb_palette_ram u_bg_ram (
    .clk        (clk),
    .reset      (reset),
    .ppu_busy   (ppu_busy),
    .spec_wr    (reg_wr && sel == REG_BCPS),
    .data_wr    (reg_wr && sel == REG_BCPD),
    .wdata      (reg_wdata),
    .spec_rdata (bg_spec_rdata),
    .data_rdata (bg_data_rdata),
    .pix_pair   ({px.pal, px.idx}),
    .pix_rgb    (bg_rgb)
  );

  cgb_palette_ram u_obj_ram (
    .clk        (clk),
    .reset      (reset),
    .ppu_busy   (ppu_busy),
    .spec_wr    (reg_wr && sel == REG_OCPS),
    .data_wr    (reg_wr && sel == REG_OCPD),
    .wdata      (reg_wdata),
    .spec_rdata (obj_spec_rdata),
    .data_rdata (obj_data_rdata),
    .pix_pair   ({px.pal, px.idx}),
    .pix_rgb    (obj_rgb)
  );

  always_comb begin
    reg_rdata = 8'hFF;
    case (sel)
      REG_BGP:  reg_rdata = bgp;
      REG_OBP0: reg_rdata = obp0;
      REG_OBP1: reg_rdata = obp1;
      REG_BCPS: reg_rdata = bg_spec_rdata;
      REG_BCPD: reg_rdata = bg_data_rdata;
      REG_OCPS: reg_rdata = obj_spec_rdata;
      REG_OCPD: reg_rdata = obj_data_rdata;
      default:  reg_rdata = 8'hFF;
    endcase
  end

  logic [7:0] x_cnt, y_cnt, pix_x, pix_y;
  assign pix_x = frame_start ? 8'd0 : x_cnt;
  assign pix_y = frame_start ? 8'd0 : y_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_cnt <= 8'd0;
      y_cnt <= 8'd0;
    end else if (pix_valid) begin
      if (pix_x == X_LAST) begin
        x_cnt <= 8'd0;
        y_cnt <= (pix_y == Y_LAST) ? 8'd0 : pix_y + 8'd1;
      end else begin
        x_cnt <= pix_x + 8'd1;
        y_cnt <= pix_y;
      end
    end else if (frame_start) begin
      x_cnt <= 8'd0;
      y_cnt <= 8'd0;
    end
  end

  // Palette data is sampled as the pixel enters stage 1, so a same-cycle write lands after it.
  logic [7:0] dmg_reg;
  assign dmg_reg = !px.is_sprite ? bgp : (px.pal[0] ? obp1 : obp0);

  logic       s1_valid, s1_cgb;
  logic [7:0] s1_x, s1_y;
  rgb555_t    s1_cgb_rgb;
  logic [1:0] s1_shade;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_cgb     <= 1'b0;
      s1_x       <= 8'd0;
      s1_y       <= 8'd0;
      s1_cgb_rgb <= 15'd0;
      s1_shade   <= 2'd0;
    end else begin
      s1_valid <= pix_valid;
      if (pix_valid) begin
        s1_cgb     <= cgb_mode;
        s1_x       <= pix_x;
        s1_y       <= pix_y;
        s1_cgb_rgb <= px.is_sprite ? obj_rgb : bg_rgb;
        s1_shade   <= dmg_reg[{px.idx, 1'b0} +: 2];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lcd_valid <= 1'b0;
      lcd_x     <= 8'd0;
      lcd_y     <= 8'd0;
      lcd_rgb   <= 15'd0;
    end else begin
      lcd_valid <= s1_valid;
      if (s1_valid) begin
        lcd_x   <= s1_x;
        lcd_y   <= s1_y;
        lcd_rgb <= s1_cgb ? s1_cgb_rgb : dmg_colour(s1_shade);
      end
    end
  end

endmodule

// File: tb/tb_pixel_palette_out.sv
// tb/tb_pixel_palette_out.sv - scoreboard bench for pixel_palette_out against a behavioural model
module tb_pixel_palette_out;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cgb_mode = 1'b0;
  logic        pix_valid = 1'b0;
  logic [5:0]  mix_pixel = 6'd0;
  logic        frame_start = 1'b0;
  logic        ppu_busy = 1'b0;
  logic [2:0]  reg_sel = 3'd7;
  logic        reg_wr = 1'b0;
  logic [7:0]  reg_wdata = 8'd0;
  logic [7:0]  reg_rdata;
  logic        lcd_valid;
  logic [7:0]  lcd_x, lcd_y;
  logic [14:0] lcd_rgb;

  pixel_palette_out dut (
    .clk         (clk),
    .reset       (reset),
    .cgb_mode    (cgb_mode),
    .pix_valid   (pix_valid),
    .mix_pixel   (mix_pixel),
    .frame_start (frame_start),
    .ppu_busy    (ppu_busy),
    .reg_sel     (reg_sel),
    .reg_wr      (reg_wr),
    .reg_wdata   (reg_wdata),
    .reg_rdata   (reg_rdata),
    .lcd_valid   (lcd_valid),
    .lcd_x       (lcd_x),
    .lcd_y       (lcd_y),
    .lcd_rgb     (lcd_rgb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int due; int x; int y; int rgb; } exp_t;
  exp_t sb[$];

  // Reference model state
  int m_bg[64], m_obj[64];
  int m_bgp, m_obp0, m_obp1;
  int m_bidx, m_bai, m_oidx, m_oai;
  int m_x, m_y;
  int shade_rgb[4] = '{32'h7FFF, 32'h56B5, 32'h294A, 32'h0000};

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin m_bg[i] = 255; m_obj[i] = 255; end
    m_bgp = 0; m_obp0 = 0; m_obp1 = 0;
    m_bidx = 0; m_bai = 0; m_oidx = 0; m_oai = 0;
    m_x = 0; m_y = 0;
  endfunction

  function automatic int model_read(input int sel, input bit busy);
    case (sel)
      0: return m_bgp;
      1: return m_obp0;
      2: return m_obp1;
      3: return m_bai * 128 + 64 + m_bidx;
      4: return busy ? 255 : m_bg[m_bidx];
      5: return m_oai * 128 + 64 + m_oidx;
      6: return busy ? 255 : m_obj[m_oidx];
      default: return 255;
    endcase
  endfunction

  function automatic void model_write(input int sel, input int wd, input bit busy);
    case (sel)
      0: m_bgp = wd;
      1: m_obp0 = wd;
      2: m_obp1 = wd;
      3: begin m_bidx = wd % 64; m_bai = wd / 128; end
      4: begin
        if (!busy) m_bg[m_bidx] = wd;
        if (m_bai != 0) m_bidx = (m_bidx + 1) % 64;
      end
      5: begin m_oidx = wd % 64; m_oai = wd / 128; end
      6: begin
        if (!busy) m_obj[m_oidx] = wd;
        if (m_oai != 0) m_oidx = (m_oidx + 1) % 64;
      end
      default: ;
    endcase
  endfunction

  function automatic int model_rgb(input int pix, input bit cgb);
    int sprite, pal, idx, a, lo, hi, r;
    sprite = pix / 32;
    pal    = (pix / 4) % 8;
    idx    = pix % 4;
    if (cgb) begin
      a  = pal * 8 + idx * 2;
      lo = sprite ? m_obj[a] : m_bg[a];
      hi = sprite ? m_obj[a + 1] : m_bg[a + 1];
      return lo + (hi % 128) * 256;
    end
    r = (sprite == 0) ? m_bgp : ((pal % 2 == 1) ? m_obp1 : m_obp0);
    return shade_rgb[(r >> (2 * idx)) % 4];
  endfunction

  // One clock of stimulus; called right after a posedge (+1)
  task automatic step(input bit v, input int pix, input bit fs, input bit wr, input int sel, input int wd);
    exp_t e;
    pix_valid   = v;
    mix_pixel   = 6'(pix);
    frame_start = fs;
    reg_wr      = wr;
    reg_sel     = 3'(sel);
    reg_wdata   = 8'(wd);
    #1;
    check("reg_rdata", int'(reg_rdata), model_read(sel, ppu_busy));
    if (v) begin
      if (fs) begin m_x = 0; m_y = 0; end
      e.due = cyc + 2;
      e.x   = m_x;
      e.y   = m_y;
      e.rgb = model_rgb(pix, cgb_mode);
      sb.push_back(e);
      m_x++;
      if (m_x == 160) begin
        m_x = 0;
        m_y = (m_y == 143) ? 0 : m_y + 1;
      end
    end else if (fs) begin
      m_x = 0; m_y = 0;
    end
    if (wr) model_write(sel, wd, ppu_busy);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 7, 0);
  endtask

  task automatic wr_reg(input int sel, input int wd);
    step(0, 0, 0, 1, sel, wd);
  endtask

  task automatic rd_const(input string name, input int sel, input int exp);
    reg_sel = 3'(sel);
    reg_wr  = 1'b0;
    #1;
    check(name, int'(reg_rdata), exp);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pixel
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (lcd_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_pixel", 1, 0);
        end else begin
          e = sb.pop_front();
          check("latency", cyc, e.due);
          check("lcd_x", int'(lcd_x), e.x);
          check("lcd_y", int'(lcd_y), e.y);
          check("lcd_rgb", int'(lcd_rgb), e.rgb);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check("missing_pixel", 0, 1);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    pix_valid = 1'b0;
    frame_start = 1'b0;
    reg_wr = 1'b0;
    sb.delete();
    model_reset();
    #1;
    check("rst_lcd_valid", int'(lcd_valid), 0);
    check("rst_lcd_x", int'(lcd_x), 0);
    check("rst_lcd_y", int'(lcd_y), 0);
    check("rst_lcd_rgb", int'(lcd_rgb), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();
    rd_const("rst_bgp", 0, 8'h00);
    rd_const("rst_bcps", 3, 8'h40);
    rd_const("rst_bcpd", 4, 8'hFF);
    rd_const("rst_ocps", 5, 8'h40);
    rd_const("rst_sel7", 7, 8'hFF);

    // DMG shades
    cgb_mode = 1'b0;
    wr_reg(0, 8'hE4);
    for (int i = 0; i < 4; i++) step(1, i, 0, 0, 7, 0);
    wr_reg(2, 8'h0C);
    step(1, 6'b100101, 0, 0, 7, 0);
    idle(3);

    // CGB auto-increment
    cgb_mode = 1'b1;
    wr_reg(3, 8'h80);
    wr_reg(4, 8'h1F);
    wr_reg(4, 8'h00);
    wr_reg(4, 8'hE0);
    wr_reg(4, 8'h03);
    rd_const("bcps_autoinc", 3, 8'hC4);
    step(1, 6'b000000, 0, 0, 7, 0);
    step(1, 6'b000001, 0, 0, 7, 0);
    idle(3);

    // Blocked write during mode 3
    wr_reg(5, 8'h82);
    ppu_busy = 1'b1;
    wr_reg(6, 8'h00);
    rd_const("ocps_blocked", 5, 8'hC3);
    rd_const("ocpd_busy", 6, 8'hFF);
    ppu_busy = 1'b0;
    rd_const("ocpd_ram3", 6, 8'hFF);
    wr_reg(5, 8'h02);
    rd_const("ocpd_ram2_kept", 6, 8'hFF);

    // Index wrap
    wr_reg(3, 8'hBF);
    wr_reg(4, 8'h11);
    wr_reg(4, 8'h22);
    rd_const("bcps_wrap", 3, 8'hC1);
    wr_reg(3, 8'h00);
    rd_const("bcpd_idx0", 4, 8'h22);

    // Same-cycle write and lookup: pixel must see the old byte
    step(1, 6'b000000, 0, 1, 4, 8'h55);
    step(1, 6'b000000, 0, 0, 7, 0);
    idle(3);

    // Randomized mix of pixels, register traffic, mode and busy changes
    for (int i = 0; i < 3000; i++) begin
      cgb_mode = 1'($urandom);
      ppu_busy = ($urandom_range(0, 3) == 0);
      step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 63)),
           ($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
    end
    ppu_busy = 1'b0;
    idle(3);

    // Full frame of coordinates with a gap in the middle
    cgb_mode = 1'b0;
    step(1, int'($urandom_range(0, 63)), 1, 0, 7, 0);
    for (int i = 1; i < 23040; i++) begin
      if (i == 5000) idle(4);
      step(1, int'($urandom_range(0, 63)), 0, 0, 7, 0);
    end
    step(1, 0, 0, 0, 7, 0);
    idle(2);
    step(0, 0, 1, 0, 7, 0);
    step(1, 3, 0, 0, 7, 0);
    idle(3);

    // Reset mid-stream
    cgb_mode = 1'b1;
    wr_reg(3, 8'h80);
    wr_reg(4, 8'h12);
    for (int i = 0; i < 5; i++) step(1, int'($urandom_range(0, 63)), 0, 0, 7, 0);
    check("pre_reset_valid", int'(lcd_valid), 1);
    do_reset();
    rd_const("post_reset_bcpd", 4, 8'hFF);
    step(1, 0, 0, 0, 7, 0);
    idle(4);

    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_palette_out.md
Name: pixel_palette_out

Overview:
- Consumer of the mixed PPU pixel stream: resolves each 6-bit mixed pixel to an RGB555 colour.
- Keeps the CGB BG/OBJ palette RAMs and the DMG BGP/OBP0/OBP1 registers, with the CPU register port.
- Tracks LCD x/y and presents a registered pixel stream to the LCD/frame-buffer writer.
- Sits between the pixel mixer and the LCD output.

Parameters:
- LCD_W, 160, visible pixels per line.
- LCD_H, 144, visible lines per frame.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cgb_mode  in  1  1 = CGB palette RAM lookup, 0 = DMG shade registers
- pix_valid  in  1  mix_pixel valid this cycle
- mix_pixel  in  6  [5] 1 = sprite, [4:2] palette number, [1:0] colour index
- frame_start  in  1  pulse; restarts x/y counters
- ppu_busy  in  1  PPU in mode 3; palette data port blocked
- reg_sel  in  3  0 BGP, 1 OBP0, 2 OBP1, 3 BCPS, 4 BCPD, 5 OCPS, 6 OCPD, 7 unused
- reg_wr  in  1  register write strobe
- reg_wdata  in  8  write data
- reg_rdata  out  8  combinational read data for reg_sel
- lcd_valid  out  1  output pixel valid
- lcd_x  out  8  pixel column 0..LCD_W-1
- lcd_y  out  8  pixel line 0..LCD_H-1
- lcd_rgb  out  15  [4:0] R, [9:5] G, [14:10] B

Behaviour:
- Reset values:
  - lcd_valid=0, lcd_x=0, lcd_y=0, lcd_rgb=0.
  - BGP/OBP0/OBP1=0x00; BCPS/OCPS index=0, auto-inc=0.
  - All 64+64 palette RAM bytes=0xFF.
  - Internal x/y counters=0.
- Latency: 2 cycles, fully pipelined, one pixel per cycle.
  - Stage 1 registers pixel, coordinates and lookup address.
  - Stage 2 registers lcd_rgb, lcd_x, lcd_y and lcd_valid. pix_valid at cycle N gives lcd_valid at N+2.
  - No back-pressure.
- Coordinates:
  - Each valid pixel takes the current x/y, then x increments.
  - x == LCD_W-1 wraps to 0 and y increments; y == LCD_H-1 with x wrap returns to y=0.
  - frame_start forces the current pixel (if valid) to x=0,y=0; the counters then continue at x=1.
  - frame_start without pix_valid: counters become 0.
- CGB lookup (cgb_mode=1):
  - RAM select = mix_pixel[5] (OBJ vs BG); byte address = {mix_pixel[4:0],1'b0}.
  - colour = {ram[a+1][6:0], ram[a]}; ram[a+1] bit 7 is ignored.
- DMG lookup (cgb_mode=0):
  - Register: BG → BGP; sprite → OBP1 if mix_pixel[2] else OBP0.
  - shade = reg[2*idx+1 : 2*idx].
  - Shade to colour: 0→0x7FFF, 1→0x56B5, 2→0x294A, 3→0x0000.
  - mix_pixel[4:3] ignored.
- BCPS/OCPS:
  - Write: index=wdata[5:0], auto-inc=wdata[7].
  - Read: {auto-inc,1'b1,index}.
- BCPD/OCPD:
  - Write stores the byte at the index unless ppu_busy.
  - If auto-inc=1, index increments (mod 64) on every BCPD/OCPD write, including blocked writes during ppu_busy. 63 wraps to 0.
  - Read returns ram[index], or 0xFF while ppu_busy. Reads never increment.
- BGP/OBP0/OBP1: always writable and readable.
- reg_sel=7: reads 0xFF, writes ignored.
- A palette write and a pixel lookup to the same byte in the same cycle: lookup sees the old value (read-before-write). Register changes take effect for pixels entering stage 1 on the next cycle.
- cgb_mode changes apply per pixel at stage 1; no flush.
- Reset mid-stream: the pipeline empties immediately and lcd_valid=0 on the next edge; the RAMs return to 0xFF.

Decomposition:
- Package lcd_pkg:
  - rgb555_t
  - mixed_pixel_t struct (is_sprite, pal[2:0], idx[1:0])
  - reg_sel enum
  - DMG shade colour constants
  - LCD_W/LCD_H defaults
- Sub-module cgb_palette_ram: 64x8 storage, index/auto-inc register, blocked-write logic, async CPU read, two-byte pixel read port.
  - Instantiated twice (BG, OBJ).

Test Plan:
- DMG shades: cgb_mode=0, BGP=0xE4; BG pixels idx 0..3 → lcd_rgb 0x7FFF, 0x56B5, 0x294A, 0x0000 at N+2. Sprite pixel idx1 with pal bit2=1 and OBP1=0x0C → 0x0000.
- CGB auto-increment: BCPS=0x80, write BCPD 0x1F,0x00 (red) then 0xE0,0x03 → BCPS reads 0xC4. BG pixel pal0 idx0 → 0x001F; idx1 → 0x03E0.
- Blocked write: OCPS=0x82, ppu_busy=1, OCPD=0x00 → ram[2] stays 0xFF, OCPS reads 0xC3, OCPD read=0xFF; ppu_busy=0 → OCPD read=0xFF (ram[3]).
- Index wrap: BCPS=0xBF, write BCPD twice → second byte lands at index 0, BCPS reads 0xC1.
- Counters: frame_start+pix_valid, then 23039 more valid pixels → last output x=159,y=143; next pixel x=0,y=0. A gap in pix_valid holds the counters.
- Reset mid-stream: reset asserted while lcd_valid=1 → outputs 0 and RAM reads 0xFF after reset; the first pixel after reset is x=0,y=0.
